// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Host-driven program loader sitting between the UART0 byte FIFOs and the
//   CPU instruction memory. It pops command bytes from the RX FIFO, assembles
//   little-endian instruction words, writes them to IMEM, drives the CPU
//   run/halt level and answers every command with a one-byte ACK (0xA5) or
//   NAK (0xEE) through the TX FIFO.
//
//   Command stream:
//     0x01 N <4*N data bytes> [checksum]  load N words starting at address 0
//     0x02                                run  (o_cpu_run = 1)
//     0x03                                halt (o_cpu_run = 0)
//     other                               NAK, run level unchanged
//
//   Optional build macro LOADER_CHECKSUM_EN: a LOAD is followed by one extra
//   byte that must equal the XOR of all data bytes; the response becomes NAK
//   on mismatch (words already written stay written).
//
// Ports:
//   clk             system clock
//   i_rst           synchronous reset, active-high
//   i_uart_rx_data  RX FIFO head (first-word-fall-through), payload in [7:0]
//   i_uart_rx_done  RX FIFO head holds a byte
//   o_uart_rd       RX pop strobe, one cycle after a byte is taken
//   o_uart_wr       TX FIFO write strobe
//   o_uart_wdata    TX byte, {0, byte}
//   o_uart_wsize    bytes to send, 1 alongside o_uart_tx_start, else 0
//   o_uart_tx_start TX start strobe
//   o_imem_we       IMEM write strobe
//   o_imem_addr     IMEM word address (holds between writes)
//   o_imem_wdata    IMEM write word (holds between writes)
//   o_cpu_run       CPU enable level
module uart_prog_loader #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int NB_UART_DATA    = 9,
  parameter int NB_UART_ADDR    = 5
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
  input  logic                       i_uart_rx_done,
  output logic                       o_uart_rd,
  output logic                       o_uart_wr,
  output logic [NB_UART_DATA-1:0]    o_uart_wdata,
  output logic [NB_UART_ADDR-1:0]    o_uart_wsize,
  output logic                       o_uart_tx_start,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_cpu_run
);

  localparam int NB_BUF = NB_INSTRUCTION - 8;
  localparam logic [7:0] LAST_BYTE = 8'(NB_INSTRUCTION / 8 - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_HALT = 8'h03;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  // S_RESP_DLY is the pop cycle of the byte that triggered a response; it
  // keeps byte-seen -> o_uart_wr at two cycles for every response source.
  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CNT,
    S_GET_DATA,
    S_WR_WORD,
    S_RESP_DLY,
    S_SEND_WR,
    S_SEND_GO
`ifdef LOADER_CHECKSUM_EN
    , S_GET_CSUM
`endif
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       take;
  logic                       accept;
  logic [7:0]                 rx_byte;
  logic                       rx_unused;
  logic                       last_word;

  logic [7:0]                 n_words;
  logic [7:0]                 word_cnt;
  logic [7:0]                 byte_idx;
  logic [IMEM_ADDR_WIDTH-1:0] addr;
  logic [NB_BUF-1:0]          word_buf;
  logic [7:0]                 resp;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                 csum;
`endif

  assign rx_byte   = i_uart_rx_data[7:0];
  assign rx_unused = ^i_uart_rx_data[NB_UART_DATA-1:8];

  // A byte is taken only when one is present and we are not in the pop
  // cycle of the previous byte (the FIFO head is still the old byte then).
  assign take      = i_uart_rx_done & ~o_uart_rd;
  assign last_word = (word_cnt == n_words - 8'd1);

  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    o_imem_we       = 1'b0;
    o_uart_wr       = 1'b0;
    o_uart_tx_start = 1'b0;
    o_uart_wdata    = '0;
    o_uart_wsize    = '0;
    case (state)
      S_IDLE: begin
        accept = take;
        if (take) begin
          state_next = (rx_byte == CMD_LOAD) ? S_GET_CNT : S_RESP_DLY;
        end
      end
      S_GET_CNT: begin
        accept = take;
        if (take) begin
          if (rx_byte != 8'd0) begin
            state_next = S_GET_DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state_next = S_GET_CSUM;
`else
            state_next = S_RESP_DLY;
`endif
          end
        end
      end
      S_GET_DATA: begin
        accept = take;
        if (take && byte_idx == LAST_BYTE) begin
          state_next = S_WR_WORD;
        end
      end
      // The pop of the final data byte overlaps this cycle, so the response
      // can start right after the last write.
      S_WR_WORD: begin
        o_imem_we = 1'b1;
        if (!last_word) begin
          state_next = S_GET_DATA;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_GET_CSUM;
`else
          state_next = S_SEND_WR;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_GET_CSUM: begin
        accept = take;
        if (take) begin
          state_next = S_RESP_DLY;
        end
      end
`endif
      S_RESP_DLY: begin
        state_next = S_SEND_WR;
      end
      S_SEND_WR: begin
        o_uart_wr    = 1'b1;
        o_uart_wdata = {{(NB_UART_DATA-8){1'b0}}, resp};
        state_next   = S_SEND_GO;
      end
      S_SEND_GO: begin
        o_uart_tx_start = 1'b1;
        o_uart_wsize    = NB_UART_ADDR'(1);
        state_next      = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      o_uart_rd    <= 1'b0;
      o_cpu_run    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      addr         <= '0;
      n_words      <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
    end else begin
      state     <= state_next;
      o_uart_rd <= accept;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (rx_byte)
              CMD_LOAD: begin
                o_cpu_run <= 1'b0;
                addr      <= '0;
                word_cnt  <= '0;
                byte_idx  <= '0;
              end
              CMD_RUN: begin
                o_cpu_run <= 1'b1;
              end
              CMD_HALT: begin
                o_cpu_run <= 1'b0;
              end
              default: begin
              end
            endcase
          end
        end
        S_GET_CNT: begin
          if (accept) begin
            n_words <= rx_byte;
          end
        end
        S_GET_DATA: begin
          if (accept) begin
            if (byte_idx == LAST_BYTE) begin
              byte_idx     <= '0;
              o_imem_wdata <= {rx_byte, word_buf};
              o_imem_addr  <= addr;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
        end
        S_WR_WORD: begin
          addr     <= addr + 1'b1;
          word_cnt <= word_cnt + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Data-only registers: their contents are always rewritten before use.
  // Bytes shift in from the top so the first byte ends up in the low lane.
  always_ff @(posedge clk) begin
    if (state == S_GET_DATA && accept) begin
      word_buf <= NB_BUF'({rx_byte, word_buf} >> 8);
    end
    if (state == S_IDLE && accept) begin
      resp <= (rx_byte == CMD_RUN || rx_byte == CMD_HALT) ? RESP_ACK : RESP_NAK;
    end else if (state == S_GET_CNT && accept) begin
      resp <= RESP_ACK;
    end
`ifdef LOADER_CHECKSUM_EN
    else if (state == S_GET_CSUM && accept) begin
      resp <= (rx_byte == csum) ? RESP_ACK : RESP_NAK;
    end
    if (state == S_IDLE && accept) begin
      csum <= 8'h00;
    end else if (state == S_GET_DATA && accept) begin
      csum <= csum ^ rx_byte;
    end
`endif
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader
//   Directed bench for uart_prog_loader (IMEM_ADDR_WIDTH = 2 so address wrap
//   is reachable). A queue models the first-word-fall-through RX FIFO; a
//   monitor logs IMEM writes and TX bytes and tracks strobe timing rules.
//   Define LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum.
module tb_uart_prog_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [8:0]    i_uart_rx_data;
  logic          i_uart_rx_done;
  logic          o_uart_rd;
  logic          o_uart_wr;
  logic [8:0]    o_uart_wdata;
  logic [4:0]    o_uart_wsize;
  logic          o_uart_tx_start;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_cpu_run;

  uart_prog_loader #(
    .NB_INSTRUCTION (32),
    .IMEM_ADDR_WIDTH(AW),
    .NB_UART_DATA   (9),
    .NB_UART_ADDR   (5)
  ) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_uart_rx_data (i_uart_rx_data),
    .i_uart_rx_done (i_uart_rx_done),
    .o_uart_rd      (o_uart_rd),
    .o_uart_wr      (o_uart_wr),
    .o_uart_wdata   (o_uart_wdata),
    .o_uart_wsize   (o_uart_wsize),
    .o_uart_tx_start(o_uart_tx_start),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wdata   (o_imem_wdata),
    .o_cpu_run      (o_cpu_run)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RX FIFO model
  logic [7:0] fifo[$];

  function automatic void refresh();
    i_uart_rx_done = (fifo.size() != 0);
    i_uart_rx_data = (fifo.size() != 0) ? {1'b0, fifo[0]} : 9'd0;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  initial begin
    i_uart_rx_done = 1'b0;
    i_uart_rx_data = '0;
    forever begin
      @(negedge clk);
      if (o_uart_rd && fifo.size() > 0) void'(fifo.pop_front());
      refresh();
    end
  end

  // Monitor
  int          cyc = 0;
  int          addr_q[$];
  logic [31:0] data_q[$];
  logic [8:0]  resp_q[$];
  int          rd_cyc_q[$];
  int          rd_cnt = 0;
  int          overlap = 0;
  int          we_long = 0;
  int          lat_err = 0;
  int          tx_err = 0;
  int          rd_in_resp = 0;
  logic        rd_prev = 1'b0;
  logic        wr_prev = 1'b0;
  logic        we_prev = 1'b0;
  logic        run_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_uart_rd === 1'b1) begin
        rd_cnt++;
        rd_cyc_q.push_back(cyc);
        if (o_uart_wr || o_uart_tx_start) rd_in_resp++;
      end
      if ((int'(o_imem_we) + int'(o_uart_wr) + int'(o_uart_tx_start)) > 1) overlap++;
      if (o_imem_we === 1'b1) begin
        addr_q.push_back(int'(o_imem_addr));
        data_q.push_back(o_imem_wdata);
        if (we_prev) we_long++;
        if (!o_uart_rd) lat_err++;
      end
      if (o_uart_wr === 1'b1) begin
        resp_q.push_back(o_uart_wdata);
        if (!rd_prev) lat_err++;
      end
      if (o_uart_tx_start === 1'b1) begin
        if (!wr_prev || o_uart_wsize != 5'd1) tx_err++;
      end else if (o_uart_wsize !== 5'd0 && !i_rst) begin
        tx_err++;
      end
      if (o_cpu_run !== run_prev && !i_rst && !o_uart_rd) lat_err++;
      rd_prev  = o_uart_rd;
      wr_prev  = o_uart_wr;
      we_prev  = o_imem_we;
      run_prev = o_cpu_run;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    resp_q.delete();
  endtask

  task automatic wait_resp(input string tag, input logic [8:0] exp);
    int k = 0;
    while (resp_q.size() == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_cnt"}, resp_q.size(), 1);
    if (resp_q.size() > 0) chk(tag, {23'd0, resp_q[0]}, {23'd0, exp});
    cycles(3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strb"}, {27'd0, o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_we, o_cpu_run}, 32'd0);
    chk({tag, "_wsize"}, {27'd0, o_uart_wsize}, 32'd0);
    chk({tag, "_wdata"}, {23'd0, o_uart_wdata}, 32'd0);
    chk({tag, "_iaddr"}, {30'd0, o_imem_addr}, 32'd0);
    chk({tag, "_iwdata"}, o_imem_wdata, 32'd0);
  endtask

  initial begin
    int k;
    int gaps;
    logic [31:0] exp_w;

    i_rst = 1'b1;
    cycles(3);
    chk_zero("reset");
    i_rst = 1'b0;
    cycles(2);

    // Load 2 words
    clear_logs();
    push(8'h01); push(8'h02);
    push(8'h13); push(8'h00); push(8'h00); push(8'h00);
    push(8'h93); push(8'h00); push(8'h10); push(8'h00);
`ifdef LOADER_CHECKSUM_EN
    push(8'h90);
`endif
    wait_resp("load2_resp", 9'h0A5);
    chk("load2_nwr", addr_q.size(), 2);
    if (addr_q.size() >= 2) begin
      chk("load2_a0", addr_q[0], 0);
      chk("load2_d0", data_q[0], 32'h0000_0013);
      chk("load2_a1", addr_q[1], 1);
      chk("load2_d1", data_q[1], 32'h0010_0093);
    end
    chk("load2_run", {31'd0, o_cpu_run}, 0);

    // RUN / unknown / HALT
    clear_logs();
    push(8'h02);
    wait_resp("run_resp", 9'h0A5);
    chk("run_level", {31'd0, o_cpu_run}, 1);
    clear_logs();
    push(8'h7F);
    wait_resp("nak_resp", 9'h0EE);
    chk("nak_level", {31'd0, o_cpu_run}, 1);
    clear_logs();
    push(8'h03);
    wait_resp("halt_resp", 9'h0A5);
    chk("halt_level", {31'd0, o_cpu_run}, 0);

    // Reset in the middle of a word
    clear_logs();
    push(8'h01); push(8'h01); push(8'h11); push(8'h22);
    k = 0;
    while (fifo.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    cycles(3);
    i_rst = 1'b1;
    cycles(3);
    chk_zero("midrst");
    i_rst = 1'b0;
    cycles(10);
    chk("midrst_nowr", addr_q.size(), 0);
    chk("midrst_noresp", resp_q.size(), 0);
    push(8'h02);
    wait_resp("midrst_run_resp", 9'h0A5);
    chk("midrst_run", {31'd0, o_cpu_run}, 1);

    // Address wrap, all bytes queued at once
    clear_logs();
    rd_cyc_q.delete();
    rd_cnt = 0;
    push(8'h01); push(8'h05);
    for (int w = 1; w <= 5; w++) begin
      push(8'(w)); push(8'h00); push(8'h00); push(8'h00);
    end
`ifdef LOADER_CHECKSUM_EN
    push(8'h01);
`endif
    wait_resp("wrap_resp", 9'h0A5);
    chk("wrap_nwr", addr_q.size(), 5);
    if (addr_q.size() >= 5) begin
      for (int w = 0; w < 5; w++) begin
        exp_w = 32'(w + 1);
        chk($sformatf("wrap_a%0d", w), addr_q[w], w % 4);
        chk($sformatf("wrap_d%0d", w), data_q[w], exp_w);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    chk("wrap_pops", rd_cnt, 23);
`else
    chk("wrap_pops", rd_cnt, 22);
`endif
    gaps = 0;
    for (int i = 1; i < rd_cyc_q.size(); i++) begin
      if (rd_cyc_q[i] - rd_cyc_q[i-1] != 2) gaps++;
    end
    chk("wrap_pop_spacing", gaps, 0);

`ifdef LOADER_CHECKSUM_EN
    clear_logs();
    push(8'h01); push(8'h01);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h44);
    wait_resp("csum_ok_resp", 9'h0A5);
    chk("csum_ok_nwr", addr_q.size(), 1);
    if (addr_q.size() >= 1) begin
      chk("csum_ok_a", addr_q[0], 0);
      chk("csum_ok_d", data_q[0], 32'h4433_2211);
    end
    clear_logs();
    push(8'h01); push(8'h01);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h45);
    wait_resp("csum_bad_resp", 9'h0EE);
    chk("csum_bad_nwr", addr_q.size(), 1);
    if (addr_q.size() >= 1) begin
      chk("csum_bad_a", addr_q[0], 0);
      chk("csum_bad_d", data_q[0], 32'h4433_2211);
    end
`endif

    cycles(5);
    chk("strobe_overlap", overlap, 0);
    chk("imem_we_width", we_long, 0);
    chk("latency", lat_err, 0);
    chk("tx_start_wsize", tx_err, 0);
    chk("pop_in_resp", rd_in_resp, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- CPU-side consumer of the UART0 byte interface: pops received bytes from the UART RX FIFO and decodes a host command stream.
- Assembles 32-bit instruction words and writes them into instruction memory.
- Drives CPU run/halt.
- Returns one-byte ACK/NAK responses through the UART TX FIFO.
- Sits in cpu_subsystem between uart_top and the IMEM write port / pipeline enable.

Parameters:
NB_INSTRUCTION, 32, instruction word width (multiple of 8)
IMEM_ADDR_WIDTH, 8, IMEM word-address width
NB_UART_DATA, 9, UART data bus width (payload in [7:0])
NB_UART_ADDR, 5, UART TX write-size width

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_uart_rx_data  in  NB_UART_DATA  RX FIFO head byte (first-word-fall-through)
i_uart_rx_done  in  1  RX byte available at FIFO head
o_uart_rd  out  1  RX pop strobe, 1 cycle
o_uart_wr  out  1  TX FIFO write strobe, 1 cycle
o_uart_wdata  out  NB_UART_DATA  TX byte, {1'b0,byte}
o_uart_wsize  out  NB_UART_ADDR  bytes to send; 1 with tx_start, else 0
o_uart_tx_start  out  1  TX start strobe, 1 cycle
o_imem_we  out  1  IMEM write strobe, 1 cycle
o_imem_addr  out  IMEM_ADDR_WIDTH  IMEM word address
o_imem_wdata  out  NB_INSTRUCTION  IMEM write word
o_cpu_run  out  1  CPU enable level

Behaviour:
- Reset: all outputs 0; state IDLE; word counter, byte index and address 0. Reset mid-operation abandons the load: no partial word is written and no response is sent.
- Byte consume rule:
  - In a byte-waiting state, a cycle with i_uart_rx_done=1 latches i_uart_rx_data[7:0].
  - o_uart_rd pulses in the following cycle (registered).
  - rx_done is ignored in the pop cycle, so at most one byte is consumed per 2 cycles.
- IDLE: wait for a command byte.
  - 0x01 LOAD: o_cpu_run<=0, addr<=0, go to GET_CNT.
  - 0x02 RUN: o_cpu_run<=1, response 0xA5.
  - 0x03 HALT: o_cpu_run<=0, response 0xA5.
  - Any other byte: response 0xEE (NAK); o_cpu_run unchanged.
- GET_CNT: the byte is N, the word count.
  - N=0: respond 0xA5 immediately.
  - Otherwise go to GET_DATA.
- GET_DATA: collect 4 bytes per word, little-endian (first byte -> [7:0]).
  - The cycle after the 4th byte is latched: o_imem_we=1, o_imem_wdata=word, o_imem_addr=addr.
  - Then addr<=addr+1, modulo 2^IMEM_ADDR_WIDTH (wrap to 0, no error).
  - After the N-th word write: respond 0xA5.
- SEND_RESP, a 2-cycle sequence, then IDLE:
  - Cycle 1: o_uart_wr=1, o_uart_wdata={0,resp}.
  - Cycle 2: o_uart_tx_start=1, o_uart_wsize=1.
  - RX bytes are not consumed during SEND_RESP; they remain in the FIFO.
- Latencies:
  - Command byte seen -> o_cpu_run change: 1 cycle.
  - Command byte seen -> o_uart_wr: 2 cycles.
  - 4th data byte seen -> o_imem_we: 1 cycle.
- Simultaneous events: only one strobe class is active per cycle. imem_we, uart_wr and tx_start never overlap.
- o_imem_addr and o_imem_wdata hold their last values between writes.
- o_cpu_run holds its level except on LOAD, RUN, HALT, or reset.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the N-th word (or directly after N=0), state GET_CSUM consumes one more byte.
  - The expected checksum is the XOR of all 4N data bytes, seeded 0x00.
  - Match -> response 0xA5; mismatch -> response 0xEE.
  - IMEM writes already performed are not reverted.
- Undefined: no checksum byte, no XOR register; LOAD always ends with 0xA5.

Test Plan:
- Reset: assert i_rst 3 cycles during GET_DATA after 2 bytes -> all outputs 0, no o_imem_we; next byte 0x02 -> o_cpu_run=1 and TX byte 0xA5.
- Load 2 words: bytes 01 02 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093, each o_imem_we 1 cycle; then o_uart_wr with 0x0A5, tx_start with wsize=1.
- Unknown command 0x7F -> o_uart_wdata=0x0EE, o_cpu_run unchanged; following 0x03 -> o_cpu_run=0, ACK 0xA5.
- Address wrap: IMEM_ADDR_WIDTH=2, LOAD N=5 with words 1..5 -> addresses 0,1,2,3,0 and final word 5 written at addr 0.
- Back-to-back rx_done held high for the whole load -> o_uart_rd pulses every 2nd cycle, exactly 2+4N pops, and no pop during SEND_RESP.
- With LOADER_CHECKSUM_EN: LOAD N=1 with bytes 11 22 33 44:
  - checksum 0x44 -> ACK 0xA5;
  - checksum 0x45 -> NAK 0xEE;
  - IMEM addr0=0x44332211 in both cases.
